// File: rtl/swc_multiport_lost_pck_dealloc_rr.sv
// Lost-packet page deallocator: latches forced page-free requests from all
// IB and OB ports, round-robins them and frees one page at a time in the MMU.
//
// Ports:
//   clk_i, rst_n_i          clock, async active-low reset
//   ib_force_free_i/_done_o per-IB request strobe / completion pulse
//   ib_pgaddr_free_i        per-IB page, port p at [p*PAGE_ADDR_BITS +: PAGE_ADDR_BITS]
//   ob_force_free_i/_done_o per-OB request strobe / completion pulse
//   ob_pgaddr_free_i        per-OB page, same packing
//   mmu_force_free_o        MMU request, held until mmu_force_free_done_i
//   mmu_force_free_addr_o   page to free, stable while the request is high
//   mmu_force_free_done_i   MMU acknowledge
//   freed_cnt_o             completed frees (SWC_LPD_STATS_EN only)
//   dropped_cnt_o           strobes ignored while pending (SWC_LPD_STATS_EN only)
//
// Macro SWC_LPD_STATS_EN adds the two saturating statistics counters.
module swc_multiport_lost_pck_dealloc_rr #(
  parameter int NUM_PORTS      = 11,
  parameter int PAGE_ADDR_BITS = 10,
  parameter int CNT_BITS       = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  logic [NUM_PORTS-1:0]                ib_force_free_i,
  input  logic [NUM_PORTS*PAGE_ADDR_BITS-1:0] ib_pgaddr_free_i,
  output logic [NUM_PORTS-1:0]                ib_force_free_done_o,
  input  logic [NUM_PORTS-1:0]                ob_force_free_i,
  input  logic [NUM_PORTS*PAGE_ADDR_BITS-1:0] ob_pgaddr_free_i,
  output logic [NUM_PORTS-1:0]                ob_force_free_done_o,
  output logic                                mmu_force_free_o,
  output logic [PAGE_ADDR_BITS-1:0]           mmu_force_free_addr_o,
  input  logic                                mmu_force_free_done_i
`ifdef SWC_LPD_STATS_EN
  ,
  output logic [CNT_BITS-1:0]                 freed_cnt_o,
  output logic [CNT_BITS-1:0]                 dropped_cnt_o
`endif
);

  localparam int N  = 2 * NUM_PORTS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = PAGE_ADDR_BITS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [N-1:0]    pending_q;
  logic [AW-1:0]   addr_q [N];
  logic [AW-1:0]   addr_in [N];
  logic [N-1:0]    strobe;
  logic [N-1:0]    accept;
  logic [N-1:0]    clr_mask;
  logic [N-1:0]    grant_oh;
  logic [N-1:0]    done_q;
  logic [IW-1:0]   rr_ptr_q;
  logic [IW-1:0]   grant_q;
  logic [IW-1:0]   pick_idx;
  logic            pick_vld;
  logic            ack;

  // Requester r: IB port p is r = p, OB port p is r = NUM_PORTS + p.
  assign strobe = {ob_force_free_i, ib_force_free_i};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
    assign addr_in[p] =
      ib_pgaddr_free_i[p*AW +: AW];
    assign addr_in[NUM_PORTS+p] =
      ob_pgaddr_free_i[p*AW +: AW];
  end

  function automatic logic [IW-1:0] wrap_add(
    input logic [IW-1:0] base,
    input int            ofs
  );
    int s;
    s = int'(base) + ofs;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // First pending requester at or after rr_ptr, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (!pick_vld &&
          pending_q[wrap_add(rr_ptr_q, i)]) begin
        pick_vld = 1'b1;
        pick_idx = wrap_add(rr_ptr_q, i);
      end
    end
  end

  assign ack      = (state_q == ST_REQ) &&
                    mmu_force_free_done_i;
  assign grant_oh = N'(1) << grant_q;
  assign clr_mask = ack ? grant_oh : '0;

  // A strobe while already pending is ignored, so a
  // capture can never collide with the grant's clear.
  assign accept = strobe & ~pending_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pending_q <= '0;
      for (int r = 0; r < N; r++) addr_q[r] <= '0;
    end else begin
      pending_q <= (pending_q & ~clr_mask) | accept;
      for (int r = 0; r < N; r++) begin
        if (accept[r]) addr_q[r] <= addr_in[r];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q               <= ST_IDLE;
      rr_ptr_q              <= '0;
      grant_q               <= '0;
      done_q                <= '0;
      mmu_force_free_o      <= 1'b0;
      mmu_force_free_addr_o <= '0;
    end else begin
      done_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            grant_q               <= pick_idx;
            mmu_force_free_addr_o <= addr_q[pick_idx];
            mmu_force_free_o      <= 1'b1;
            state_q               <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mmu_force_free_done_i) begin
            mmu_force_free_o <= 1'b0;
            rr_ptr_q         <= wrap_add(grant_q, 1);
            done_q           <= grant_oh;
            state_q          <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ib_force_free_done_o = done_q[NUM_PORTS-1:0];
  assign ob_force_free_done_o = done_q[N-1:NUM_PORTS];

`ifdef SWC_LPD_STATS_EN
  localparam int SW = CNT_BITS + IW + 1;

  logic [N-1:0] drop;
  logic [IW:0]  drop_n;
  logic [SW-1:0] drop_sum;

  assign drop = strobe & pending_q;

  always_comb begin
    drop_n = '0;
    for (int r = 0; r < N; r++) begin
      drop_n = drop_n + (IW+1)'(drop[r]);
    end
  end

  assign drop_sum = SW'(dropped_cnt_o) + SW'(drop_n);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      freed_cnt_o   <= '0;
      dropped_cnt_o <= '0;
    end else begin
      if (ack && (freed_cnt_o != '1))
        freed_cnt_o <= freed_cnt_o + 1'b1;
      if (|drop_sum[SW-1:CNT_BITS])
        dropped_cnt_o <= '1;
      else
        dropped_cnt_o <= drop_sum[CNT_BITS-1:0];
    end
  end
`endif

endmodule
